// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-Lite arbiter and bus multiplexer.
// Shares one subordinate port between NUM_MASTERS managers, holds the grant
// for whole fixed-length bursts and routes write data from the data-phase owner.
module ahb_rr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_MASTERS = 4
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [NUM_MASTERS-1:0]           m_hbusreq,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MASTERS*2-1:0]         m_htrans,
  input  logic [NUM_MASTERS-1:0]           m_hwrite,
  input  logic [NUM_MASTERS*3-1:0]         m_hburst,
  input  logic [NUM_MASTERS*3-1:0]         m_hsize,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]           m_hgrant,
  output logic [ADDR_WIDTH-1:0]            haddr,
  output logic [1:0]                       htrans,
  output logic                             hwrite,
  output logic [2:0]                       hburst,
  output logic [2:0]                       hsize,
  output logic [DATA_WIDTH-1:0]            hwdata,
  input  logic                             hready,
  input  logic [1:0]                       hresp,
  input  logic [DATA_WIDTH-1:0]            hrdata,
  output logic                             m_hready,
  output logic [1:0]                       m_hresp,
  output logic [DATA_WIDTH-1:0]            m_hrdata,
  output logic [2:0]                       owner_id,
  output logic                             busy
);

  typedef enum logic {
    PARK  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t                  state_q, state_d;
  logic [2:0]              owner_q, owner_d;
  logic [2:0]              ptr_q, ptr_d;
  logic [2:0]              data_owner_q, data_owner_d;
  logic                    data_valid_q, data_valid_d;
  logic [3:0]              beat_cnt_q, beat_cnt_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;

  logic [ADDR_WIDTH-1:0]   own_addr;
  logic [1:0]              own_trans;
  logic                    own_write;
  logic [2:0]              own_burst;
  logic [2:0]              own_size;
  logic                    own_req;
  logic [DATA_WIDTH-1:0]   wdata_mux;

  logic [2:0]              base;
  logic                    found;
  logic [2:0]              winner;
  logic [NUM_MASTERS-1:0]  winner_oh;

  logic                    beat_acc;
  logic                    is_incr;
  logic [3:0]              burst_last;
  logic [3:0]              cnt_next;
  logic                    final_beat;
  logic                    arb_point;

  // Remaining beats after the NONSEQ beat; INCR has no fixed end so it loads zero.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      3'd6, 3'd7: burst_len_m1 = 4'd15;
      default:    burst_len_m1 = 4'd0;
    endcase
  endfunction

  // Select the address-phase owner's request and control fields, and the data-phase owner's write data.
  always_comb begin
    own_addr  = '0;
    own_trans = TRANS_IDLE;
    own_write = 1'b0;
    own_burst = 3'd0;
    own_size  = 3'd0;
    own_req   = 1'b0;
    wdata_mux = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == 3'(i)) begin
        own_addr  = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_trans = m_htrans[i*2 +: 2];
        own_write = m_hwrite[i];
        own_burst = m_hburst[i*3 +: 3];
        own_size  = m_hsize[i*3 +: 3];
        own_req   = m_hbusreq[i];
      end
      if (data_valid_q && (data_owner_q == 3'(i))) begin
        wdata_mux = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Cyclic search for the first requester after the current owner (or the pointer when parked); the base itself is tried last.
  always_comb begin
    base      = (state_q == OWNED) ? owner_q : ptr_q;
    found     = 1'b0;
    winner    = 3'd0;
    winner_oh = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && m_hbusreq[i] && (i == ((int'(base) + k) % NUM_MASTERS))) begin
          found        = 1'b1;
          winner       = 3'(i);
          winner_oh[i] = 1'b1;
        end
      end
    end
  end

  // Beat acceptance, burst counting and detection of the arbitration point.
  always_comb begin
    beat_acc   = (state_q == OWNED) && hready && own_trans[1];
    is_incr    = (own_burst == 3'd1);
    burst_last = burst_len_m1(own_burst);
    if (own_trans == TRANS_NONSEQ) begin
      cnt_next = burst_last;
    end else if (beat_cnt_q == 4'd0) begin
      cnt_next = 4'd0;
    end else begin
      cnt_next = beat_cnt_q - 4'd1;
    end
    final_beat = beat_acc && !is_incr && (cnt_next == 4'd0);
    arb_point  = (state_q == OWNED) && hready &&
                 (final_beat ||
                  ((own_trans == TRANS_IDLE) && !own_req) ||
                  (beat_acc && is_incr && !own_req) ||
                  (hresp != 2'b00));
  end

  // Next-state logic; a wait state (hready low) holds every register.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    beat_cnt_d   = beat_cnt_q;
    grant_d      = grant_q;
    if (hready) begin
      data_valid_d = beat_acc;
      if (beat_acc) begin
        beat_cnt_d   = cnt_next;
        data_owner_d = owner_q;
      end
      case (state_q)
        PARK: begin
          if (found) begin
            state_d = OWNED;
            owner_d = winner;
            ptr_d   = winner;
            grant_d = winner_oh;
          end
        end
        OWNED: begin
          if (arb_point) begin
            if (found) begin
              owner_d = winner;
              ptr_d   = winner;
              grant_d = winner_oh;
            end else begin
              state_d = PARK;
              grant_d = '0;
            end
          end
        end
        default: begin
          state_d = PARK;
          grant_d = '0;
        end
      endcase
    end
  end

  // Arbiter registers; reset parks the bus with manager 0 next in line.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= PARK;
      owner_q      <= 3'd0;
      ptr_q        <= 3'(NUM_MASTERS - 1);
      data_owner_q <= 3'd0;
      data_valid_q <= 1'b0;
      beat_cnt_q   <= 4'd0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_q      <= grant_d;
    end
  end

  // Drive the shared bus from the owner, forcing IDLE when no grant is held, and pass the response through.
  always_comb begin
    busy     = (state_q == OWNED);
    owner_id = owner_q;
    m_hgrant = grant_q;
    haddr    = busy ? own_addr  : '0;
    htrans   = busy ? own_trans : TRANS_IDLE;
    hwrite   = busy ? own_write : 1'b0;
    hburst   = busy ? own_burst : 3'd0;
    hsize    = busy ? own_size  : 3'd0;
    hwdata   = wdata_mux;
    m_hready = hready;
    m_hresp  = hresp;
    m_hrdata = hrdata;
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Testbench for ahb_rr_arbiter: cycle vectors with expected grant and write
// data, checked through a scoreboard queue one cycle at a time.
module tb_ahb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] SQ   = 2'b11;

  localparam logic [31:0] WD0 = 32'h0000_D000;
  localparam logic [31:0] WD1 = 32'h0000_A5A5;
  localparam logic [31:0] WD2 = 32'h0000_C2C2;
  localparam logic [31:0] WD3 = 32'h0000_E3E3;

  typedef struct {
    logic [3:0]  req;
    int          mst;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  burst;
    logic        rdy;
    logic [1:0]  resp;
    logic [3:0]  e_grant;
    logic [31:0] e_hwdata;
    logic [31:0] rdata;
  } vec_t;

  logic              hclk;
  logic              hresetn;
  logic [NM-1:0]     m_hbusreq;
  logic [NM*AW-1:0]  m_haddr;
  logic [NM*2-1:0]   m_htrans;
  logic [NM-1:0]     m_hwrite;
  logic [NM*3-1:0]   m_hburst;
  logic [NM*3-1:0]   m_hsize;
  logic [NM*DW-1:0]  m_hwdata;
  logic [NM-1:0]     m_hgrant;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic [DW-1:0]     hwdata;
  logic              hready;
  logic [1:0]        hresp;
  logic [DW-1:0]     hrdata;
  logic              m_hready;
  logic [1:0]        m_hresp;
  logic [DW-1:0]     m_hrdata;
  logic [2:0]        owner_id;
  logic              busy;

  int   compared;
  int   failed;
  vec_t sb_q[$];
  vec_t tbl_rr[$];
  vec_t tbl_main[$];

  ahb_rr_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_MASTERS(NM)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .m_hbusreq(m_hbusreq),
    .m_haddr  (m_haddr),
    .m_htrans (m_htrans),
    .m_hwrite (m_hwrite),
    .m_hburst (m_hburst),
    .m_hsize  (m_hsize),
    .m_hwdata (m_hwdata),
    .m_hgrant (m_hgrant),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hburst   (hburst),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hready   (hready),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .m_hready (m_hready),
    .m_hresp  (m_hresp),
    .m_hrdata (m_hrdata),
    .owner_id (owner_id),
    .busy     (busy)
  );

  // Free-running bus clock.
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] req, input int mst, input logic [1:0] trans,
                              input logic [31:0] addr, input logic write, input logic [2:0] burst,
                              input logic rdy, input logic [1:0] resp, input logic [3:0] grant,
                              input logic [31:0] wdata);
    vec_t v;
    v.req = req; v.mst = mst; v.trans = trans; v.addr = addr; v.write = write;
    v.burst = burst; v.rdy = rdy; v.resp = resp; v.e_grant = grant;
    v.e_hwdata = wdata; v.rdata = 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of manager/subordinate inputs and queue the expected outputs.
  task automatic applyStimulus(input vec_t v);
    vec_t e;
    e = v;
    e.rdata = $urandom;
    m_hbusreq = v.req;
    hready    = v.rdy;
    hresp     = v.resp;
    hrdata    = e.rdata;
    for (int i = 0; i < NM; i++) begin
      if (i == v.mst) begin
        m_haddr[i*AW +: AW] = v.addr;
        m_htrans[i*2 +: 2]  = v.trans;
        m_hwrite[i]         = v.write;
        m_hburst[i*3 +: 3]  = v.burst;
        m_hsize[i*3 +: 3]   = 3'b001;
      end else begin
        m_haddr[i*AW +: AW] = 32'hF000_0000 | (32'(i) << 8);
        m_htrans[i*2 +: 2]  = IDLE;
        m_hwrite[i]         = 1'b1;
        m_hburst[i*3 +: 3]  = 3'b111;
        m_hsize[i*3 +: 3]   = 3'b010;
      end
    end
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT drives now.
  task automatic checkOutput();
    vec_t       e;
    logic       busy_e;
    logic [2:0] owner_e;
    if (sb_q.size() == 0) begin
      compared++;
      failed++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    busy_e  = |e.e_grant;
    owner_e = 3'd0;
    for (int i = 0; i < NM; i++) if (e.e_grant[i]) owner_e = 3'(i);
    chk("m_hgrant", 32'(m_hgrant), 32'(e.e_grant));
    chk("busy", 32'(busy), 32'(busy_e));
    if (busy_e) chk("owner_id", 32'(owner_id), 32'(owner_e));
    chk("haddr", haddr, busy_e ? e.addr : 32'h0);
    chk("htrans", 32'(htrans), busy_e ? 32'(e.trans) : 32'h0);
    chk("hwrite", 32'(hwrite), busy_e ? 32'(e.write) : 32'h0);
    chk("hburst", 32'(hburst), busy_e ? 32'(e.burst) : 32'h0);
    chk("hsize", 32'(hsize), busy_e ? 32'h1 : 32'h0);
    chk("hwdata", hwdata, e.e_hwdata);
    chk("m_hready", 32'(m_hready), 32'(e.rdy));
    chk("m_hresp", 32'(m_hresp), 32'(e.resp));
    chk("m_hrdata", m_hrdata, e.rdata);
  endtask

  // Main sequence: reset, round robin, single/burst/wait/error table, reset mid-burst.
  initial begin
    compared = 0;
    failed   = 0;
    m_hwdata = {WD3, WD2, WD1, WD0};
    hresetn  = 1'b0;

    // Round robin with everyone requesting single transfers.
    tbl_rr.push_back(mk(4'hF, -1, IDLE, 32'h0,  1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, 32'h0));
    tbl_rr.push_back(mk(4'hF,  0, NS,   32'h10, 1'b1, 3'd0, 1'b1, 2'd0, 4'b0001, 32'h0));
    tbl_rr.push_back(mk(4'hF,  1, NS,   32'h14, 1'b0, 3'd0, 1'b1, 2'd0, 4'b0010, WD0));
    tbl_rr.push_back(mk(4'hF,  2, NS,   32'h18, 1'b1, 3'd0, 1'b1, 2'd0, 4'b0100, WD1));
    tbl_rr.push_back(mk(4'hF,  3, NS,   32'h1C, 1'b0, 3'd0, 1'b1, 2'd0, 4'b1000, WD2));
    tbl_rr.push_back(mk(4'h0,  0, NS,   32'h20, 1'b1, 3'd0, 1'b1, 2'd0, 4'b0001, WD3));
    tbl_rr.push_back(mk(4'h0, -1, IDLE, 32'h0,  1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, WD0));
    tbl_rr.push_back(mk(4'h0, -1, IDLE, 32'h0,  1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, 32'h0));

    // Single write by manager 1.
    tbl_main.push_back(mk(4'b0010, -1, IDLE, 32'h0,   1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, 32'h0));
    tbl_main.push_back(mk(4'b0000,  1, NS,   32'h40,  1'b1, 3'd0, 1'b1, 2'd0, 4'b0010, 32'h0));
    tbl_main.push_back(mk(4'b0000, -1, IDLE, 32'h0,   1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, WD1));
    // INCR4 by manager 0 with manager 2 requesting from beat 2.
    tbl_main.push_back(mk(4'b0001, -1, IDLE, 32'h0,   1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, 32'h0));
    tbl_main.push_back(mk(4'b0001,  0, NS,   32'h100, 1'b1, 3'd3, 1'b1, 2'd0, 4'b0001, 32'h0));
    tbl_main.push_back(mk(4'b0101,  0, SQ,   32'h104, 1'b1, 3'd3, 1'b1, 2'd0, 4'b0001, WD0));
    tbl_main.push_back(mk(4'b0101,  0, SQ,   32'h108, 1'b1, 3'd3, 1'b1, 2'd0, 4'b0001, WD0));
    tbl_main.push_back(mk(4'b0100,  0, SQ,   32'h10C, 1'b1, 3'd3, 1'b1, 2'd0, 4'b0001, WD0));
    tbl_main.push_back(mk(4'b0100,  2, IDLE, 32'h200, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD0));
    // INCR8 by manager 2 with three wait states, manager 3 waiting.
    tbl_main.push_back(mk(4'b0100,  2, NS,   32'h200, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, 32'h0));
    tbl_main.push_back(mk(4'b0100,  2, SQ,   32'h204, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h208, 1'b0, 3'd5, 1'b0, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h208, 1'b0, 3'd5, 1'b0, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h208, 1'b0, 3'd5, 1'b0, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h208, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h20C, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h210, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h214, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1100,  2, SQ,   32'h218, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    tbl_main.push_back(mk(4'b1000,  2, SQ,   32'h21C, 1'b0, 3'd5, 1'b1, 2'd0, 4'b0100, WD2));
    // INCR16 by manager 3 cut short by an error on beat 2.
    tbl_main.push_back(mk(4'b1001,  3, NS,   32'h300, 1'b1, 3'd7, 1'b1, 2'd0, 4'b1000, WD2));
    tbl_main.push_back(mk(4'b1001,  3, SQ,   32'h304, 1'b1, 3'd7, 1'b1, 2'd1, 4'b1000, WD3));
    tbl_main.push_back(mk(4'b0001,  0, IDLE, 32'h400, 1'b0, 3'd3, 1'b1, 2'd0, 4'b0001, WD3));
    // Manager 0 starts an INCR4 that reset will interrupt.
    tbl_main.push_back(mk(4'b0001,  0, NS,   32'h400, 1'b0, 3'd3, 1'b1, 2'd0, 4'b0001, 32'h0));
    tbl_main.push_back(mk(4'b0001,  0, SQ,   32'h404, 1'b0, 3'd3, 1'b1, 2'd0, 4'b0001, WD0));

    // Reset state.
    @(negedge hclk);
    applyStimulus(mk(4'h0, -1, IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, 32'h0));
    #1 checkOutput();
    @(posedge hclk);
    #2 hresetn = 1'b1;

    foreach (tbl_rr[n]) begin
      @(negedge hclk);
      applyStimulus(tbl_rr[n]);
      #1 checkOutput();
    end

    foreach (tbl_main[n]) begin
      @(negedge hclk);
      applyStimulus(tbl_main[n]);
      #1 checkOutput();
    end

    // Asynchronous reset in the middle of the INCR4 drops the grant at once.
    @(negedge hclk);
    applyStimulus(mk(4'hF, 0, SQ, 32'h408, 1'b0, 3'd3, 1'b1, 2'd0, 4'b0000, 32'h0));
    #2 hresetn = 1'b0;
    #1 checkOutput();

    // After release, manager 0 wins first even though everyone requests.
    @(negedge hclk);
    applyStimulus(mk(4'hF, -1, IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, 32'h0));
    hresetn = 1'b1;
    #1 checkOutput();
    @(negedge hclk);
    applyStimulus(mk(4'h0, 0, NS, 32'h500, 1'b1, 3'd0, 1'b1, 2'd0, 4'b0001, 32'h0));
    #1 checkOutput();
    @(negedge hclk);
    applyStimulus(mk(4'h0, -1, IDLE, 32'h0, 1'b0, 3'd0, 1'b1, 2'd0, 4'b0000, WD0));
    #1 checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
